// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        HEADER,
        LOAD,
        RUN,
        ERROR
    } loader_state_t;

    localparam int HEADER_BYTES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; word length is selected at run time by last_idx.
module byte_assembler #(
    parameter int NBYTES = 4,
    localparam int CW = $clog2(NBYTES) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_en,
    input  logic [7:0]          byte_data,
    input  logic [CW-1:0]       last_idx,
    output logic [8*NBYTES-1:0] word,
    output logic                word_complete
);

    logic [CW-1:0]       cnt_q;
    logic [8*NBYTES-1:0] word_q;

    // word already includes the byte being accepted, so the final byte is visible with word_complete
    always_comb begin
        word = word_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt_q == CW'(k)) begin
                word[8*k +: 8] = byte_data;
            end
        end
        word_complete = byte_en && (cnt_q == last_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (byte_en) begin
            word_q <= word;
            cnt_q  <= word_complete ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a byte stream (32-bit LE count, then LE words) while holding the core in reset.
module program_loader
    import loader_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          MEM_WORDS = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            reload,
    output logic            imem_write_en,
    output logic [XLEN-1:0] imem_write_addr,
    output logic [XLEN-1:0] imem_write_data,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);

    localparam int BPW = XLEN / 8;
    localparam int NB  = max_int(HEADER_BYTES, BPW);
    localparam int CW  = $clog2(NB) + 1;
    localparam logic [31:0]     MAX_N = 32'(MEM_WORDS);
    localparam logic [XLEN-1:0] BASE  = BASE_ADDR[XLEN-1:0];

    loader_state_t   state_q, state_d;
    logic            byte_en, asm_done, asm_clear;
    logic [CW-1:0]   last_idx;
    logic [8*NB-1:0] asm_word;
    logic [31:0]     hdr_count, n_words_q, word_cnt_q;
    logic            vld_p1, run_p1;
    logic [XLEN-1:0] addr_p1, data_p1;

    assign in_ready  = (state_q == HEADER) || (state_q == LOAD);
    assign byte_en   = in_valid && in_ready;
    assign asm_clear = (state_q == RUN) && reload;
    assign last_idx  = (state_q == HEADER) ? CW'(HEADER_BYTES - 1) : CW'(BPW - 1);
    assign hdr_count = asm_word[31:0];

    byte_assembler #(.NBYTES(NB)) u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear),
        .byte_en       (byte_en),
        .byte_data     (in_data),
        .last_idx      (last_idx),
        .word          (asm_word),
        .word_complete (asm_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HEADER: begin
                if (asm_done) begin
                    if (hdr_count == 32'd0) begin
                        state_d = RUN;
                    end else if (hdr_count > MAX_N) begin
                        state_d = ERROR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (asm_done && (word_cnt_q == n_words_q - 32'd1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = HEADER;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // stage p1: registered write strobe/address/data, one cycle after the final byte of a word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words_q  <= '0;
            word_cnt_q <= '0;
            vld_p1     <= 1'b0;
            addr_p1    <= BASE;
            data_p1    <= '0;
            run_p1     <= 1'b0;
        end else begin
            vld_p1 <= (state_q == LOAD) && asm_done;
            // the write cycle itself is already RUN, so the core is released one cycle later
            run_p1 <= (state_d == RUN) && (state_q != LOAD);
            if (state_q == HEADER && asm_done) begin
                n_words_q  <= hdr_count;
                word_cnt_q <= '0;
            end
            if (state_q == LOAD && asm_done) begin
                addr_p1    <= BASE + XLEN'(word_cnt_q) * XLEN'(BPW);
                data_p1    <= asm_word[XLEN-1:0];
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (asm_clear) begin
                n_words_q  <= '0;
                word_cnt_q <= '0;
            end
        end
    end

    assign imem_write_en   = vld_p1;
    assign imem_write_addr = addr_p1;
    assign imem_write_data = data_p1;
    assign cpu_reset       = run_p1;
    assign done            = run_p1;
    assign error           = (state_q == ERROR);

endmodule
